// File: rtl/seven_seg_pkg.sv
// seven_seg_pkg: active-low {g..a} glyph constants shared with the display driver,
// plus the capture FSM states.
package seven_seg_pkg;
    localparam logic [6:0] SEG_0     = 7'b1000000;
    localparam logic [6:0] SEG_1     = 7'b1111001;
    localparam logic [6:0] SEG_2     = 7'b0100100;
    localparam logic [6:0] SEG_3     = 7'b0110000;
    localparam logic [6:0] SEG_4     = 7'b0011001;
    localparam logic [6:0] SEG_5     = 7'b0010010;
    localparam logic [6:0] SEG_6     = 7'b0000010;
    localparam logic [6:0] SEG_7     = 7'b1111000;
    localparam logic [6:0] SEG_8     = 7'b0000000;
    localparam logic [6:0] SEG_9     = 7'b0010000;
    localparam logic [6:0] SEG_A     = 7'b0001000;
    localparam logic [6:0] SEG_B     = 7'b0000011;
    localparam logic [6:0] SEG_C     = 7'b1000110;
    localparam logic [6:0] SEG_D     = 7'b0100001;
    localparam logic [6:0] SEG_E     = 7'b0000110;
    localparam logic [6:0] SEG_F     = 7'b0001110;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    typedef enum logic {COLLECT, HOLD} state_t;
endpackage

// File: rtl/seg_glyph_decode.sv
// seg_glyph_decode: active-low segment pattern to hex value; blank is unlit,
// any other unknown pattern is lit with value 0 and flagged.
module seg_glyph_decode
    import seven_seg_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_value,
    output logic       o_lit,
    output logic       o_err
);
    always_comb begin
        o_value = 4'h0;
        o_lit   = 1'b1;
        o_err   = 1'b0;
        case (i_seg)
            SEG_BLANK: o_lit = 1'b0;
            SEG_0:     o_value = 4'h0;
            SEG_1:     o_value = 4'h1;
            SEG_2:     o_value = 4'h2;
            SEG_3:     o_value = 4'h3;
            SEG_4:     o_value = 4'h4;
            SEG_5:     o_value = 4'h5;
            SEG_6:     o_value = 4'h6;
            SEG_7:     o_value = 4'h7;
            SEG_8:     o_value = 4'h8;
            SEG_9:     o_value = 4'h9;
            SEG_A:     o_value = 4'hA;
            SEG_B:     o_value = 4'hB;
            SEG_C:     o_value = 4'hC;
            SEG_D:     o_value = 4'hD;
            SEG_E:     o_value = 4'hE;
            SEG_F:     o_value = 4'hF;
            default:   o_err = 1'b1;
        endcase
    end
endmodule

// File: rtl/seven_seg_capture.sv
// seven_seg_capture: rebuilds the 4-digit frame from the multiplexed seven-segment scan bus.
// Define SEVEN_SEG_CAPTURE_DP_EN to capture decimal points; otherwise dp is ignored.
module seven_seg_capture
    import seven_seg_pkg::*;
#(
    parameter int STABLE_CYCLES  = 16,
    parameter int TIMEOUT_CYCLES = 400000
) (
    input  logic       clk25,
    input  logic       rst,
    input  logic [6:0] seg,
    input  logic       dp,
    input  logic [3:0] an,
    output logic [3:0] num3,
    output logic [3:0] num2,
    output logic [3:0] num1,
    output logic [3:0] num0,
    output logic [3:0] mask,
    output logic [3:0] dp_out,
    output logic       seg_err,
    output logic       timeout,
    output logic       frame_valid,
    input  logic       frame_ready
);
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [SW-1:0] S_MAX = SW'(STABLE_CYCLES);
    localparam logic [TW-1:0] T_MAX = TW'(TIMEOUT_CYCLES);

    logic w_dp;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
    assign w_dp = dp;
`else
    logic w_unused_dp;
    assign w_unused_dp = dp;
    assign w_dp = 1'b1;
`endif

    // bus layout {an[3:0], seg[6:0], dp}
    logic [11:0]     r_s1, r_s2, r_prev;
    logic [SW-1:0]   r_stab;
    logic [TW-1:0]   r_to;
    logic            r_armed, r_err;
    state_t          r_state;
    logic [3:0]      r_seen, r_lit, r_dpc;
    logic [3:0][3:0] r_val;
    logic [3:0]      w_oh, w_val;
    logic [1:0]      w_idx;
    logic            w_chg, w_an_chg, w_cap, w_full, w_tmo, w_lit, w_gerr;

    assign w_chg    = r_s2 != r_prev;
    assign w_an_chg = r_s2[11:8] != r_prev[11:8];
    assign w_oh     = ~r_prev[11:8];
    assign w_idx    = {w_oh[3] | w_oh[2], w_oh[3] | w_oh[1]};
    assign w_cap    = (r_stab == S_MAX) && r_armed && $onehot(w_oh);
    assign w_full   = r_seen == 4'hF;
    assign w_tmo    = (r_seen != 4'h0) && !w_cap && (r_to == T_MAX);

    seg_glyph_decode u_dec (
        .i_seg   (r_prev[7:1]),
        .o_value (w_val),
        .o_lit   (w_lit),
        .o_err   (w_gerr)
    );

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_s1    <= '1;
            r_s2    <= '1;
            r_prev  <= '1;
            r_stab  <= '0;
            r_armed <= 1'b1;
        end else begin
            r_s1    <= {an, seg, w_dp};
            r_s2    <= r_s1;
            r_prev  <= r_s2;
            r_stab  <= w_chg ? '0 : (r_stab == S_MAX) ? r_stab : r_stab + 1'b1;
            r_armed <= w_an_chg | (r_armed & ~w_cap);
        end
    end

    always_ff @(posedge clk25 or posedge rst) begin
        if (rst) begin
            r_state     <= COLLECT;
            r_seen      <= '0;
            r_lit       <= '0;
            r_dpc       <= '0;
            r_val       <= '0;
            r_err       <= 1'b0;
            r_to        <= '0;
            num3        <= '0;
            num2        <= '0;
            num1        <= '0;
            num0        <= '0;
            mask        <= '0;
            dp_out      <= '0;
            seg_err     <= 1'b0;
            timeout     <= 1'b0;
            frame_valid <= 1'b0;
        end else if (r_state == COLLECT) begin
            if (w_cap) begin
                r_val[w_idx]  <= w_val;
                r_lit[w_idx]  <= w_lit;
                r_dpc[w_idx]  <= ~r_prev[0];
                r_seen[w_idx] <= 1'b1;
                r_err         <= r_err | w_gerr;
            end
            r_to <= w_cap ? '0 : (r_to == T_MAX) ? r_to : r_to + 1'b1;
            // slots never captured this frame publish as unlit zeros
            if (w_full || w_tmo) begin
                num3        <= r_seen[3] ? r_val[3] : 4'h0;
                num2        <= r_seen[2] ? r_val[2] : 4'h0;
                num1        <= r_seen[1] ? r_val[1] : 4'h0;
                num0        <= r_seen[0] ? r_val[0] : 4'h0;
                mask        <= r_lit & r_seen;
                dp_out      <= r_dpc & r_seen;
                seg_err     <= r_err;
                timeout     <= !w_full;
                frame_valid <= 1'b1;
                r_state     <= HOLD;
            end
        end else if (frame_ready) begin
            r_seen      <= '0;
            r_err       <= 1'b0;
            r_to        <= '0;
            frame_valid <= 1'b0;
            r_state     <= COLLECT;
        end
    end
endmodule

// File: tb/tb_seven_seg_capture.sv
// tb_seven_seg_capture: random and directed scan frames checked against a
// frame-level model of what the display shows.
module tb_seven_seg_capture;
    localparam int S  = 16;
    localparam int T  = 2000;
    localparam int DW = 40;

    logic       clk25 = 1'b0, rst = 1'b1;
    logic [6:0] seg = '1;
    logic       dp = 1'b1;
    logic [3:0] an = '1;
    logic       frame_ready = 1'b0;
    logic [3:0] num3, num2, num1, num0, mask, dp_out;
    logic       seg_err, timeout, frame_valid;
    int         n_tests = 0, n_fail = 0;

    logic [6:0] glyph [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};
    // per digit: kind 0 = hex glyph, 1 = blank, 2 = non-glyph pattern
    int         kind [4];
    logic [3:0] hv [4];
    logic       dv [4];
    logic [6:0] pt [4];
    logic [31:0] exp_a;

    always #20 clk25 = ~clk25;

    seven_seg_capture #(.STABLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
        .clk25(clk25), .rst(rst), .seg(seg), .dp(dp), .an(an),
        .num3(num3), .num2(num2), .num1(num1), .num0(num0),
        .mask(mask), .dp_out(dp_out), .seg_err(seg_err), .timeout(timeout),
        .frame_valid(frame_valid), .frame_ready(frame_ready)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] observed();
        return {6'd0, num3, num2, num1, num0, mask, dp_out, seg_err, timeout};
    endfunction

    function automatic logic [31:0] model(input logic [3:0] seen, input logic to);
        logic [15:0] n = '0;
        logic [3:0]  m = '0, d = '0;
        logic        e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (seen[i]) begin
                n[4*i +: 4] = (kind[i] == 0) ? hv[i] : 4'h0;
                m[i] = kind[i] != 1;
                e |= kind[i] == 2;
`ifdef SEVEN_SEG_CAPTURE_DP_EN
                d[i] = ~dv[i];
`endif
            end
        end
        return {6'd0, n, m, d, e, to};
    endfunction

    function automatic logic is_known(input logic [6:0] p);
        for (int i = 0; i < 16; i++) if (glyph[i] == p) return 1'b1;
        return p == 7'h7F;
    endfunction

    task automatic set_slot(input int i, input int k, input logic [3:0] v);
        kind[i] = k;
        hv[i]   = v;
        dv[i]   = 1'($urandom_range(0, 1));
        if (k == 0) pt[i] = glyph[v];
        else if (k == 1) pt[i] = 7'h7F;
        else begin
            pt[i] = 7'($urandom);
            while (is_known(pt[i])) pt[i] = 7'($urandom);
        end
    endtask

    task automatic random_frame();
        for (int i = 0; i < 4; i++) begin
            int r = $urandom_range(0, 9);
            set_slot(i, r < 7 ? 0 : (r < 9 ? 1 : 2), 4'($urandom));
        end
    endtask

    task automatic drive(input int i, input int cycles);
        an  = ~(4'b0001 << i);
        seg = pt[i];
        dp  = dv[i];
        repeat (cycles) @(negedge clk25);
    endtask

    task automatic scan(input int rounds);
        repeat (rounds) for (int i = 3; i >= 0; i--) drive(i, DW);
    endtask

    task automatic dark(input int cycles);
        an = '1; seg = '1; dp = 1'b1;
        repeat (cycles) @(negedge clk25);
    endtask

    task automatic wait_valid(input string tag, input int limit);
        int k = 0;
        while (!frame_valid && k < limit) begin
            @(negedge clk25);
            k++;
        end
        check(tag, {31'd0, frame_valid}, 32'd1);
    endtask

    task automatic handshake();
        frame_ready = 1'b1;
        @(negedge clk25);
        frame_ready = 1'b0;
        check("valid_drop", {31'd0, frame_valid}, 32'd0);
    endtask

    initial begin
        #4000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        repeat (4) @(negedge clk25);
        check("reset_out", observed(), 32'd0);
        check("reset_valid", {31'd0, frame_valid}, 32'd0);
        rst = 1'b0;
        repeat (4) @(negedge clk25);
        check("post_reset_valid", {31'd0, frame_valid}, 32'd0);

        set_slot(3, 0, 4'h1); set_slot(2, 0, 4'h2); set_slot(1, 0, 4'h3); set_slot(0, 0, 4'h4);
        scan(1);
        wait_valid("basic_valid", 100);
        check("basic_frame", observed(), model(4'hF, 1'b0));
        check("basic_nums", {16'd0, num3, num2, num1, num0}, 32'h1234);
        check("basic_mask", {28'd0, mask}, 32'hF);
        handshake();
        dark(10);

        repeat (8) begin
            random_frame();
            scan(1);
            wait_valid("rand_valid", 100);
            check("rand_frame", observed(), model(4'hF, 1'b0));
            handshake();
            dark(10);
        end

        for (int i = 0; i < 4; i++) set_slot(i, 0, 4'($urandom));
        kind[2] = 2;
        pt[2] = 7'b1010101;
        scan(1);
        wait_valid("err_valid", 100);
        check("err_frame", observed(), model(4'hF, 1'b0));
        check("err_flag", {31'd0, seg_err}, 32'd1);
        check("err_num2_mask2", {27'd0, num2, mask[2]}, 32'd1);
        handshake();
        dark(10);

        for (int i = 0; i < 4; i++) set_slot(i, 0, 4'($urandom));
        set_slot(2, 0, 4'h8);
        drive(2, S - 1);
        drive(3, DW); drive(1, DW); drive(0, DW);
        dark(500);
        check("short_no_frame", {31'd0, frame_valid}, 32'd0);
        wait_valid("short_to_valid", T + 200);
        check("short_frame", observed(), model(4'b1011, 1'b1));
        handshake();
        dark(10);

        set_slot(0, 0, 4'h7);
        drive(0, T / 2);
        check("to_not_early", {31'd0, frame_valid}, 32'd0);
        wait_valid("to_valid", T + 200);
        check("to_frame", observed(), model(4'b0001, 1'b1));
        check("to_num0_mask", {24'd0, num0, mask}, 32'h71);
        handshake();
        dark(T + 100);
        check("dark_no_frame", {31'd0, frame_valid}, 32'd0);

        random_frame();
        scan(1);
        wait_valid("hold_first_valid", 100);
        exp_a = model(4'hF, 1'b0);
        check("hold_first_frame", observed(), exp_a);
        random_frame();
        fork
            scan(40);
            begin
                for (int j = 0; j < 10; j++) begin
                    repeat (500) @(negedge clk25);
                    check("hold_frame", observed(), exp_a);
                    check("hold_valid", {31'd0, frame_valid}, 32'd1);
                end
                handshake();
                wait_valid("next_valid", 600);
                check("next_frame", observed(), model(4'hF, 1'b0));
            end
        join
        handshake();
        dark(10);

        random_frame();
        drive(3, DW);
        drive(2, DW);
        rst = 1'b1;
        repeat (3) @(negedge clk25);
        check("midrst_out", observed(), 32'd0);
        check("midrst_valid", {31'd0, frame_valid}, 32'd0);
        rst = 1'b0;
        drive(1, DW);
        drive(0, DW);
        dark(500);
        check("midrst_partial", {31'd0, frame_valid}, 32'd0);
        scan(1);
        wait_valid("midrst_fresh_valid", 100);
        check("midrst_fresh_frame", observed(), model(4'hF, 1'b0));
        handshake();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/seven_seg_capture.md
# seven_seg_capture

Multiplexed seven-segment capture block: samples the active-low `seg`/`dp`/`an` scan bus that drives the 4-digit display and reconstructs the four hex digits, blanking mask and decimal points. Captured frames are presented over a valid/ready handshake. It is the reading end of the display interface, used for on-board loopback checking of the display path and for logging displayed timer values.

## Interface
- `STABLE_CYCLES`, 16: consecutive unchanged cycles of {an,seg,dp} required before a digit is captured; minimum 2.
- `TIMEOUT_CYCLES`, 400000: cycles without a capture before a partial frame is published (16 ms at 25 MHz).
- `clk25` in 1: 25 MHz clock.
- `rst` in 1: reset, asynchronous, active-high.
- `seg` in 7: segment lines, active-low, {g,f,e,d,c,b,a} = seg[6:0].
- `dp` in 1: decimal point, active-low.
- `an` in 4: digit enables, active-low; an[0] is the rightmost digit.
- `num3`..`num0` out 4 each: decoded hex digits.
- `mask` out 4: 1 = digit was lit (non-blank) in the frame.
- `dp_out` out 4: 1 = decimal point lit on that digit.
- `seg_err` out 1: some captured non-blank pattern was not a hex glyph.
- `timeout` out 1: frame was published by the timeout path.
- `frame_valid` out 1: frame outputs valid.
- `frame_ready` in 1: consumer accepts the frame.

## Operation
- Inputs pass through a 2-flop synchronizer. All logic uses the synchronized copies.
- Stability counter: resets to 0 on any change of {an,seg,dp}; otherwise it increments and saturates at STABLE_CYCLES.
- Capture happens when the counter reaches STABLE_CYCLES, `an` has exactly one bit low, and the armed flag is set. The armed flag is set on every change of `an`, so each activation yields at most one capture.
- `an` values 4'b1111 or multi-low are ignored.
- Per capture, digit slot i = index of the low `an` bit:
  - Pattern 7'b1111111: value 0, lit 0.
  - Table hit: table value, lit 1.
  - Miss: value 0, lit 1, error flag for the frame set.
  - `seen[i]` set.
- Glyph table, active-low {g..a}: 0 1000000, 1 1111001, 2 0100100, 3 0110000, 4 0011001, 5 0010010, 6 0000010, 7 1111000, 8 0000000, 9 0010000, A 0001000, b 0000011, C 1000110, d 0100001, E 0000110, F 0001110.
- FSM:
  - COLLECT: if seen == 4'b1111, publish and go to HOLD. If the timeout counter reaches TIMEOUT_CYCLES with seen != 0, publish with unseen slots forced to value 0, lit 0, `timeout`=1, and go to HOLD. If seen == 0, the timeout counter holds at its limit, so a dark display publishes nothing.
  - HOLD: `frame_valid`=1 and outputs frozen. Captures are dropped. On `frame_valid` & `frame_ready`: clear seen, the error flag and the timeout counter, then go to COLLECT.
- The timeout counter clears on every capture and on entry to COLLECT.
- Re-capture of an already-seen slot in COLLECT overwrites that slot.
- Reset mid-frame discards all partial state.

## Timing
- Reset values: all outputs 0, state COLLECT, seen 0, armed 1, counters 0.
- Capture occurs 2 (sync) + STABLE_CYCLES cycles after the bus settles.
- `frame_valid` rises on the cycle after the capture or timeout that completes the frame.
- `frame_valid` falls on the cycle after the handshake. Earliest next frame is 4 captures later.
- Outputs change only on the publish cycle.
- Simultaneous capture and timeout in the same cycle: the capture wins and the timeout counter clears.

## Configuration
- `SEVEN_SEG_CAPTURE_DP_EN` defined: `dp` is included in the stability compare and captured per slot. `dp_out[i]` = ~dp at capture.
- Not defined: `dp` is ignored entirely and `dp_out` is tied to 4'b0000.

## Structure
- Shared package `seven_seg_pkg`: glyph constants SEG_0..SEG_F and SEG_BLANK (shared with the display driver), and the FSM state enum {COLLECT, HOLD}.
- One sub-module: `seg_glyph_decode`, combinational 7-bit pattern to {value[3:0], lit, err}.

## Test plan
- Cycle an[3..0] low with glyphs 1,2,3,4, 1000 cycles each -> `frame_valid`, num3..0=1,2,3,4, mask=1111, seg_err=0, timeout=0.
- Only an[0] low with glyph 7, others 4'b1111 -> after TIMEOUT_CYCLES: num0=7, mask=0001, timeout=1.
- Hold an[2] low for STABLE_CYCLES-1 then change -> no capture, seen[2]=0.
- Hold `frame_ready`=0 for 5000 cycles while scanning new values -> outputs and `frame_valid` stable. One-cycle ready -> valid=0 next cycle, new frame follows.
- Pattern 7'b1010101 on digit 2 -> seg_err=1, num2=0, mask[2]=1.
- Assert rst after 2 captures -> all outputs 0. Post-reset frame requires 4 fresh captures.
